keypad_scanner: RTL and testbench

- Matrix-keypad front end that produces the 4-bit key codes consumed by the password/login block.
- Drives a 4x4 keypad column-by-column and samples the rows.
- Debounces one key per press and emits its code with a one-cycle strobe.
- Sits between the physical keypad pins and the keyPadInput bus of the elevator top level. The login/lock status can suppress key entry.

---
 rtl/keypad_scanner_if.sv | 40 ++++
 rtl/keypad_scanner.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// ----------------------------------------------------------------------------
// keypad_scanner_if
//   Groups the keypad pins and the key-code bus of keypad_scanner.
//   Signals:
//     row_n     keypad rows [4:1], active-low, asynchronous to clk
//     lock      suppresses key strobes while high
//     col_n     keypad column drives [4:1], active-low one-hot
//     key_code  code of the last accepted key
//     key_valid one-cycle strobe when key_code is updated
//     key_held  high while an accepted key remains pressed
//   Modports:
//     slave  - the scanner itself
//     master - the environment (keypad pins and login block)
// ----------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic       lock;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport slave (
        input  row_n,
        input  lock,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output row_n,
        output lock,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//   4x4 matrix keypad front end. Drives the columns one at a time, samples the
//   synchronized rows, classifies each full scan (none / single / multi) and
//   debounces one key per press. An accepted press updates key_code with a
//   one-cycle key_valid strobe unless lock is high.
//
//   Ports:
//     clk  system clock
//     rst  synchronous, active-low reset
//     kp   keypad_scanner_if.slave (row_n, lock in; col_n, key_code,
//          key_valid, key_held out)
//
//   Parameters:
//     SCAN_DIV       cycles each column is driven before its rows are sampled
//     DEBOUNCE_SCANS identical full scans needed to accept a press or release
//     REPEAT_SCANS   full scans between auto-repeat strobes
//
//   Build option:
//     KEYPAD_REPEAT_EN  when defined, a held key re-strobes every REPEAT_SCANS
//                       full scans; when undefined no repeat logic exists.
//
//   Key code for row r / column c (1-based) is (r-1)*4+(c-1), i.e. the 2-bit
//   row index concatenated with the 2-bit column index.
// ----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.slave   kp
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_SCANS);
    localparam bit            DEB_ONE  = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    // Number of active (low) rows in one column sample.
    function automatic logic [2:0] hit_count(input logic [3:0] hits);
        hit_count = {2'b00, hits[0]} + {2'b00, hits[1]}
                  + {2'b00, hits[2]} + {2'b00, hits[3]};
    endfunction

    // Index of the lowest active row; only meaningful when one row is active.
    function automatic logic [1:0] first_row(input logic [3:0] hits);
        if (hits[0]) begin
            first_row = 2'd0;
        end else if (hits[1]) begin
            first_row = 2'd1;
        end else if (hits[2]) begin
            first_row = 2'd2;
        end else begin
            first_row = 2'd3;
        end
    endfunction

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col;
    logic [3:0]    r_col_n;
    logic [1:0]    r_acc_cnt;     // keys seen so far this scan, saturates at 2
    logic [3:0]    r_acc_code;

    state_t        r_state;
    logic [3:0]    r_cand;
    logic [CW-1:0] r_cnt;         // press debounce count, reused for release
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_held;

    logic          w_sample;
    logic          w_scan_end;
    logic [1:0]    w_col_next;
    logic [3:0]    w_col_hits;
    logic [2:0]    w_tot_cnt;
    logic [3:0]    w_tot_code;
    logic          w_none;
    logic          w_single;

    state_t        w_state_nx;
    logic [3:0]    w_cand_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_code_nx;
    logic          w_valid_nx;
    logic          w_held_nx;
    logic          w_accept;
    logic          w_fire;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_N = RW'(REPEAT_SCANS);
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_nx;
    logic          w_repeat;
`endif

    // Scan timing and the full-scan classification of the current sample.
    always_comb begin
        w_sample   = (r_div == DIV_LAST);
        w_scan_end = w_sample && (r_col == 2'd3);
        w_col_next = r_col + 2'd1;
        w_col_hits = ~r_row_sync;
        w_tot_cnt  = {1'b0, r_acc_cnt} + hit_count(w_col_hits);
        if (r_acc_cnt == 2'd0) begin
            w_tot_code = {first_row(w_col_hits), r_col};
        end else begin
            w_tot_code = r_acc_code;
        end
        w_none   = (w_tot_cnt == 3'd0);
        w_single = (w_tot_cnt == 3'd1);
    end

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
        end else begin
            r_row_meta <= kp.row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Column dwell counter, column drive and per-scan key accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div      <= '0;
            r_col      <= 2'd0;
            r_col_n    <= 4'b1110;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'h0;
        end else if (w_sample) begin
            r_div   <= '0;
            r_col   <= w_col_next;
            r_col_n <= ~(4'b0001 << w_col_next);
            if (r_col == 2'd3) begin
                r_acc_cnt  <= 2'd0;
                r_acc_code <= 4'h0;
            end else begin
                r_acc_cnt  <= (w_tot_cnt > 3'd1) ? 2'd2 : w_tot_cnt[1:0];
                r_acc_code <= w_tot_code;
            end
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Debounce FSM next state and output values, evaluated once per full scan.
    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        w_code_nx  = r_key_code;
        w_valid_nx = 1'b0;
        w_held_nx  = r_key_held;
        w_accept   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_repeat   = 1'b0;
        w_rep_nx   = kp.lock ? '0 : r_rep_cnt;
`endif
        if (w_scan_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nx = w_tot_code;
                        w_cnt_nx  = CW'(1);
                        if (DEB_ONE) begin
                            w_state_nx = ST_PRESSED;
                            w_accept   = 1'b1;
                        end else begin
                            w_state_nx = ST_CANDIDATE;
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_CANDIDATE: begin
                    if (w_single) begin
                        if (w_tot_code == r_cand) begin
                            if (r_cnt + CW'(1) == DEB_N) begin
                                w_state_nx = ST_PRESSED;
                                w_accept   = 1'b1;
                            end else begin
                                w_cnt_nx = r_cnt + CW'(1);
                            end
                        end else begin
                            w_cand_nx = w_tot_code;
                            w_cnt_nx  = CW'(1);
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_none) begin
`ifdef KEYPAD_REPEAT_EN
                        w_rep_nx = '0;
`endif
                        if (DEB_ONE) begin
                            w_state_nx = ST_IDLE;
                            w_held_nx  = 1'b0;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_RELEASING;
                            w_cnt_nx   = CW'(1);
                        end
                    end else begin
                        w_state_nx = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        if (w_single && (w_tot_code == r_cand) && !kp.lock) begin
                            if (r_rep_cnt + RW'(1) == REP_N) begin
                                w_rep_nx = '0;
                                w_repeat = 1'b1;
                            end else begin
                                w_rep_nx = r_rep_cnt + RW'(1);
                            end
                        end else begin
                            w_rep_nx = '0;
                        end
`endif
                    end
                end
                ST_RELEASING: begin
                    if (w_none) begin
                        if (r_cnt + CW'(1) == DEB_N) begin
                            w_state_nx = ST_IDLE;
                            w_held_nx  = 1'b0;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx = r_cnt + CW'(1);
                        end
                    end else begin
                        // Release bounce: the key stays accepted, no new strobe.
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = '0;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_nx   = '0;
`endif
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_held_nx  = 1'b0;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end

        // A press accepted under lock is consumed silently.
`ifdef KEYPAD_REPEAT_EN
        w_rep_nx = w_accept ? '0 : w_rep_nx;
        w_fire   = (w_accept && !kp.lock) || w_repeat;
`else
        w_fire   = w_accept && !kp.lock;
`endif
        w_held_nx  = w_held_nx | w_accept;
        w_valid_nx = w_fire;
        w_code_nx  = w_fire ? w_cand_nx : w_code_nx;
    end

    // Debounce FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'h0;
            r_cnt       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cand      <= w_cand_nx;
            r_cnt       <= w_cnt_nx;
            r_key_code  <= w_code_nx;
            r_key_valid <= w_valid_nx;
            r_key_held  <= w_held_nx;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat scan counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_nx;
        end
    end
`endif

    assign kp.col_n     = r_col_n;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner. A keypad model turns a 16-bit
//   "pressed" vector and the column drives into row levels. Stimulus pushes
//   the expected key code of every strobe into a queue; a monitor pops and
//   compares on each key_valid.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DEB  = 3;
    localparam int REP  = 5;
    localparam int SCAN = 4 * SD;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    logic [15:0] pressed;
    logic        rand_mode;
    logic [3:0]  rand_rows;
    logic [3:0]  rows_model;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.col_n[c]) begin
                    rows_model[r] = 1'b0;
                end
            end
        end
    end

    assign kif.row_n = rand_mode ? rand_rows : rows_model;

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         n_strobes = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst === 1'b1 && kif.key_valid === 1'b1) begin
            n_strobes++;
            check("valid_not_back_to_back", int'(prev_valid), 0);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got code %0h, expected no strobe", kif.key_code);
            end else begin
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    n_fail++;
                    $display("FAIL strobe_code: got %0h, expected %0h", kif.key_code, e);
                end
            end
        end
        prev_valid = kif.key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic val, input int max, input string name);
        int t = 0;
        while (kif.key_held !== val && t < max) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(name, int'(kif.key_held), int'(val));
    endtask

    task automatic wait_strobe(input int max, input string name, output int t);
        int start = n_strobes;
        t = 0;
        while (n_strobes == start && t < max) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(name, n_strobes - start, 1);
    endtask

    initial begin
        int         lat;
        int         base;
        int         c;
        logic [3:0] e_col;

        rst       = 1'b0;
        pressed   = 16'h0000;
        rand_mode = 1'b1;
        rand_rows = 4'hF;
        kif.lock  = 1'b0;

        // Reset with random rows, then check reset state and column sequence.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_rows = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst       = 1'b1;
        rand_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rst_key_code", int'(kif.key_code), 0);
                check("rst_key_valid", int'(kif.key_valid), 0);
                check("rst_key_held", int'(kif.key_held), 0);
            end
            c        = ((i + 1) / SD) % 4;
            e_col    = 4'hF;
            e_col[c] = 1'b0;
            check("col_scan", int'(kif.col_n), int'(e_col));
        end

        // Reset during debounce discards the candidate without a strobe.
        pressed[5] = 1'b1;
        tick(30);
        check("mid_deb_not_held", int'(kif.key_held), 0);
        rst        = 1'b0;
        pressed[5] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(5 * SCAN);
        check("mid_deb_code", int'(kif.key_code), 0);
        check("mid_deb_held", int'(kif.key_held), 0);
        check("mid_deb_no_strobe", n_strobes, 0);

        // Steady press row2/col3 -> one strobe with 6, latency window, release.
        exp_q.push_back(4'h6);
        pressed[6] = 1'b1;
        wait_strobe(70, "t2_strobe", lat);
        check("t2_latency_min", int'(lat >= (DEB - 1) * SCAN), 1);
        check("t2_code", int'(kif.key_code), 6);
        check("t2_held", int'(kif.key_held), 1);
        base = n_strobes;
        tick(3 * SCAN);
        pressed[6] = 1'b0;
        tick(20);
        check("t2_held_during_release_debounce", int'(kif.key_held), 1);
        wait_held(1'b0, 5 * SCAN, "t2_release");
        check("t2_single_strobe", n_strobes - base, 0);

        // Bouncing row4/col1: no strobe while bouncing, one strobe once stable.
        base = n_strobes;
        for (int k = 0; k < 10; k++) begin
            pressed[12] = ~pressed[12];
            tick(12);
        end
        check("t3_no_strobe_bounce", n_strobes - base, 0);
        exp_q.push_back(4'hC);
        pressed[12] = 1'b1;
        wait_strobe(70, "t3_strobe", lat);
        check("t3_code", int'(kif.key_code), 12);
        pressed[12] = 1'b0;
        wait_held(1'b0, 5 * SCAN, "t3_release");

        // Two keys together: treated as invalid.
        base        = n_strobes;
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        tick(20 * SCAN);
        check("t4_no_strobe", n_strobes - base, 0);
        check("t4_code_kept", int'(kif.key_code), 12);
        check("t4_not_held", int'(kif.key_held), 0);
        pressed = 16'h0000;
        tick(4 * SCAN);

        // Locked press is consumed; unlock while held does not replay it.
        base        = n_strobes;
        kif.lock    = 1'b1;
        pressed[10] = 1'b1;
        wait_held(1'b1, 80, "t5_locked_held");
        check("t5_locked_code", int'(kif.key_code), 12);
        kif.lock = 1'b0;
        tick(5 * SCAN);
        check("t5_still_held", int'(kif.key_held), 1);
        check("t5_no_strobe", n_strobes - base, 0);
        pressed[10] = 1'b0;
        wait_held(1'b0, 5 * SCAN, "t5_release");
        exp_q.push_back(4'hA);
        pressed[10] = 1'b1;
        wait_strobe(70, "t5_strobe", lat);
        check("t5_code", int'(kif.key_code), 10);
        pressed[10] = 1'b0;
        wait_held(1'b0, 5 * SCAN, "t5_release2");

        // Long hold of 4'h3: one strobe, or acceptance plus repeats.
        base = n_strobes;
`ifdef KEYPAD_REPEAT_EN
        for (int k = 0; k < 4; k++) exp_q.push_back(4'h3);
`else
        exp_q.push_back(4'h3);
`endif
        pressed[3] = 1'b1;
        tick(22 * SCAN);
`ifdef KEYPAD_REPEAT_EN
        check("t6_strobe_count", n_strobes - base, 4);
`else
        check("t6_strobe_count", n_strobes - base, 1);
`endif
        check("t6_code", int'(kif.key_code), 3);
        pressed[3] = 1'b0;
        wait_held(1'b0, 5 * SCAN, "t6_release");

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
